dmem_arbiter: RTL and testbench

//  Shares the single-port data memory (dm) among the CORES execution cores of the cpu.

---
 rtl/dmem_arbiter_pkg.sv | 19 +
 rtl/dmem_arbiter_rr_arbiter.sv | 35 +++
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter slice.
package dmem_arbiter_pkg;

    localparam int DEF_CORES = 4;
    localparam int DEF_AW    = 10;
    localparam int DEF_DW    = 32;

    // Access type as carried on core_we / mem_we.
    typedef enum logic {
        ACC_LOAD  = 1'b0,
        ACC_STORE = 1'b1
    } acc_t;

    // Width of a core index; a single core still needs one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int N  = DEF_CORES,
    parameter int PW = ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    // Walk offsets from the farthest to the nearest so the nearest hit wins.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                gnt_onehot      = '0;
                gnt_onehot[idx] = 1'b1;
                gnt_idx         = PW'(idx);
                any             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory among CORES load/store units, one
// access per cycle, round-robin, with a one-cycle ack and a per-core load bank.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int CORES = DEF_CORES,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CORES-1:0]    core_req,
    input  logic [CORES-1:0]    core_we,
    input  logic [CORES*AW-1:0] core_addr,
    input  logic [CORES*DW-1:0] core_wdata,
    output logic [CORES-1:0]    core_ack,
    output logic [CORES*DW-1:0] core_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata
);

    localparam int PW = ptr_w(CORES);

    logic [AW-1:0]    addr_arr  [CORES];
    logic [DW-1:0]    wdata_arr [CORES];
    logic [DW-1:0]    rdata_reg [CORES];

    logic [PW-1:0]    rr_ptr_reg;
    logic             inflight_vld_reg;
    logic [PW-1:0]    inflight_id_reg;
    acc_t             inflight_acc_reg;
    logic [CORES-1:0] inflight_mask;
    logic [CORES-1:0] eligible;
    logic [CORES-1:0] ack_reg;

    logic             mem_en_reg;
    logic             mem_we_reg;
    logic [AW-1:0]    mem_addr_reg;
    logic [DW-1:0]    mem_wdata_reg;

    logic [CORES-1:0] gnt_onehot;
    logic [PW-1:0]    gnt_idx;
    logic             gnt_any;
    logic [PW-1:0]    rr_ptr_next;

    genvar gi;
    generate
        for (gi = 0; gi < CORES; gi++) begin : g_slice
            assign addr_arr[gi]               = core_addr[gi*AW +: AW];
            assign wdata_arr[gi]              = core_wdata[gi*DW +: DW];
            assign core_rdata[gi*DW +: DW]    = rdata_reg[gi];
        end
    endgenerate

    // The core whose access is in flight is held off until its ack has gone out.
    always_comb begin
        inflight_mask = '0;
        if (inflight_vld_reg) begin
            inflight_mask[inflight_id_reg] = 1'b1;
        end
    end

    assign eligible = core_req & ~inflight_mask;

    rr_arbiter #(
        .N  (CORES),
        .PW (PW)
    ) u_rr (
        .req        (eligible),
        .ptr        (rr_ptr_reg),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    assign rr_ptr_next = (gnt_idx == PW'(CORES - 1)) ? '0 : gnt_idx + PW'(1);

    // Launch the granted access toward dm and note which core owns it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_reg       <= '0;
            inflight_vld_reg <= 1'b0;
            inflight_id_reg  <= '0;
            inflight_acc_reg <= ACC_LOAD;
            mem_en_reg       <= 1'b0;
            mem_we_reg       <= 1'b0;
            mem_addr_reg     <= '0;
            mem_wdata_reg    <= '0;
        end else if (gnt_any) begin
            rr_ptr_reg       <= rr_ptr_next;
            inflight_vld_reg <= 1'b1;
            inflight_id_reg  <= gnt_idx;
            inflight_acc_reg <= acc_t'(core_we[gnt_idx]);
            mem_en_reg       <= 1'b1;
            mem_we_reg       <= core_we[gnt_idx];
            mem_addr_reg     <= addr_arr[gnt_idx];
            mem_wdata_reg    <= wdata_arr[gnt_idx];
        end else begin
            inflight_vld_reg <= 1'b0;
            mem_en_reg       <= 1'b0;
            mem_we_reg       <= 1'b0;
        end
    end

    // The in-flight mask is already the one-hot ack for the completing core.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_reg <= '0;
        end else begin
            ack_reg <= inflight_mask;
        end
    end

    generate
        for (gi = 0; gi < CORES; gi++) begin : g_rbank
            // Capture dm read data for this core's completing load; stores leave it alone.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rdata_reg[gi] <= '0;
                end else if (inflight_vld_reg && inflight_acc_reg == ACC_LOAD &&
                             inflight_id_reg == PW'(gi)) begin
                    rdata_reg[gi] <= mem_rdata;
                end
            end
        end
    endgenerate

    assign core_ack  = ack_reg;
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model (ordered memory + round-robin rule).
module tb_dmem_arbiter;

    localparam int CORES = 4;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic                clk = 1'b0;
    logic                reset;
    logic [CORES-1:0]    core_req;
    logic [CORES-1:0]    core_we;
    logic [CORES*AW-1:0] core_addr;
    logic [CORES*DW-1:0] core_wdata;
    logic [CORES-1:0]    core_ack;
    logic [CORES*DW-1:0] core_rdata;
    logic                mem_en;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic [DW-1:0]       mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.CORES(CORES), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ack   (core_ack),
        .core_rdata (core_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // dm: the arbiter's registered address is dm's address register, so read
    // data is presented while the strobe is up and captured at the next edge.
    logic [DW-1:0] dm [0:DEPTH-1];
    assign mem_rdata = dm[mem_addr];
    always @(posedge clk) begin
        if (mem_en && mem_we) dm[mem_addr] <= mem_wdata;
    end

    // Reference model state.
    logic [DW-1:0]    gm [0:DEPTH-1];
    int               m_ptr;
    bit               m_vld;
    int               m_id;
    bit               m_we;
    logic [DW-1:0]    m_val;
    logic             e_en, e_we;
    logic [AW-1:0]    e_addr;
    logic [DW-1:0]    e_wdata;
    logic [CORES-1:0] e_ack;
    logic [DW-1:0]    e_rdata [CORES];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ack_q[$];
    int ack_cyc [CORES];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_vld = 0; m_id = 0; m_we = 0; m_val = '0;
        e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_ack = '0;
        for (int i = 0; i < CORES; i++) e_rdata[i] = '0;
    endtask

    // One clock edge of the abstract behaviour: finish the previous access,
    // then pick the next requester round-robin, skipping the one finishing.
    task automatic model_edge();
        int g;
        if (reset) begin
            model_reset();
            return;
        end
        e_ack = '0;
        if (m_vld) begin
            e_ack[m_id] = 1'b1;
            if (!m_we) e_rdata[m_id] = m_val;
        end
        g = -1;
        for (int k = 0; k < CORES; k++) begin
            int c;
            c = (m_ptr + k) % CORES;
            if (g < 0 && core_req[c] && !(m_vld && m_id == c)) g = c;
        end
        if (g >= 0) begin
            e_en    = 1'b1;
            e_we    = core_we[g];
            e_addr  = core_addr[g*AW +: AW];
            e_wdata = core_wdata[g*DW +: DW];
            if (core_we[g]) gm[e_addr] = e_wdata;
            else            m_val = gm[e_addr];
            m_vld = 1; m_id = g; m_we = core_we[g];
            m_ptr = (g + 1) % CORES;
        end else begin
            e_en = 1'b0;
            e_we = 1'b0;
            m_vld = 0;
        end
    endtask

    task automatic compare();
        check("mem_en",    128'(mem_en),    128'(e_en));
        check("mem_we",    128'(mem_we),    128'(e_we));
        check("mem_addr",  128'(mem_addr),  128'(e_addr));
        check("mem_wdata", 128'(mem_wdata), 128'(e_wdata));
        check("core_ack",  128'(core_ack),  128'(e_ack));
        for (int i = 0; i < CORES; i++)
            check("core_rdata", 128'(core_rdata[i*DW +: DW]), 128'(e_rdata[i]));
    endtask

    task automatic set_core(input int c, input bit we, input int addr, input logic [DW-1:0] wd);
        core_req[c]              = 1'b1;
        core_we[c]               = we;
        core_addr[c*AW +: AW]    = AW'(addr);
        core_wdata[c*DW +: DW]   = wd;
    endtask

    // Advance one cycle, check, log acks, and let acked cores drop their request.
    task automatic tick(input bit rnd);
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        compare();
        for (int i = 0; i < CORES; i++) begin
            if (core_ack[i]) begin
                ack_q.push_back(i);
                ack_cyc[i] = cyc;
                $display("cycle %0d ack core %0d %s rdata=%h", cyc, i,
                         core_we[i] ? "sw" : "lw", core_rdata[i*DW +: DW]);
                core_req[i] = 1'b0;
            end
        end
        if (rnd) begin
            for (int i = 0; i < CORES; i++) begin
                if (!core_req[i] && $urandom_range(0, 99) < 45)
                    set_core(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom);
            end
        end
    endtask

    task automatic wait_ack(input int c, output int seen);
        seen = -1;
        for (int n = 0; n < 20 && seen < 0; n++) begin
            tick(0);
            if (core_ack[c]) seen = cyc;
        end
        if (seen < 0) check("ack_timeout", 128'(0), 128'(1));
    endtask

    task automatic check_order(input string tag, input int a, input int b);
        check({tag, "_count"}, 128'(ack_q.size()), 128'(2));
        if (ack_q.size() >= 2) begin
            check({tag, "_first"},  128'(ack_q[0]), 128'(a));
            check({tag, "_second"}, 128'(ack_q[1]), 128'(b));
        end
    endtask

    initial begin
        int t_sw, t_lw, raise, last1;
        bit got0;
        reset = 1'b1;
        core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
        for (int a = 0; a < DEPTH; a++) begin
            dm[a] = DW'(a * 3 + 1);
            gm[a] = DW'(a * 3 + 1);
        end
        model_reset();
        #1;
        compare();
        tick(0); tick(0);
        reset = 1'b0;

        // 1: all cores load word i, dm[0..3] = 100..103.
        for (int i = 0; i < CORES; i++) begin
            dm[i] = DW'(100 + i);
            gm[i] = DW'(100 + i);
            set_core(i, 0, i, '0);
        end
        ack_q.delete();
        for (int n = 0; n < 7; n++) tick(0);
        check("t1_nack", 128'(ack_q.size()), 128'(4));
        for (int i = 0; i < CORES; i++) begin
            if (ack_q.size() > i) check("t1_order", 128'(ack_q[i]), 128'(i));
            check("t1_rdata", 128'(core_rdata[i*DW +: DW]), 128'(100 + i));
            if (i > 0) check("t1_consec", 128'(ack_cyc[i] - ack_cyc[i-1]), 128'(1));
        end

        // 2: core 2 stores DEAD at 5, then loads it back.
        set_core(2, 1, 5, 32'hDEAD);
        wait_ack(2, t_sw);
        check("t2_sw_keep", 128'(core_rdata[2*DW +: DW]), 128'(102));
        set_core(2, 0, 5, '0);
        wait_ack(2, t_lw);
        check("t2_gap", 128'(t_lw - t_sw >= 2), 128'(1));
        check("t2_rdata", 128'(core_rdata[2*DW +: DW]), 128'(32'hDEAD));
        check("t2_dm", 128'(dm[5]), 128'(32'hDEAD));
        tick(0);

        // 3: pointer sits at 3; cores 0 and 3 request together.
        ack_q.delete();
        set_core(0, 0, 20, '0);
        set_core(3, 0, 23, '0);
        for (int n = 0; n < 5; n++) tick(0);
        check_order("t3", 3, 0);
        // Pointer should now be 1: cores 0 and 1 together -> 1 first.
        ack_q.delete();
        set_core(0, 0, 30, '0);
        set_core(1, 0, 31, '0);
        for (int n = 0; n < 5; n++) tick(0);
        check_order("t3_ptr", 1, 0);

        // 4: core 1 streams loads; core 0 joins mid-stream.
        set_core(1, 0, 32, '0);
        raise = -1; last1 = -1; got0 = 0;
        for (int n = 0; n < 14; n++) begin
            tick(0);
            if (core_ack[1]) begin
                if (last1 >= 0) check("t4_c1_gap", 128'(cyc - last1 >= 2), 128'(1));
                last1 = cyc;
                set_core(1, 0, 33 + n, '0);
            end
            if (core_ack[0]) begin
                check("t4_c0_wait", 128'(cyc - raise <= 3), 128'(1));
                got0 = 1;
            end
            if (n == 4) begin
                set_core(0, 0, 64, '0);
                raise = cyc;
            end
        end
        check("t4_c0_served", 128'(got0), 128'(1));
        for (int n = 0; n < 4; n++) tick(0);

        // 5: reset one cycle after granting core 2.
        set_core(2, 0, 7, '0);
        tick(0);
        check("t5_grant", 128'(mem_en), 128'(1));
        reset = 1'b1;
        core_req = '0;
        model_reset();
        #1;
        check("t5_ack", 128'(core_ack), 128'(0));
        check("t5_en", 128'(mem_en), 128'(0));
        check("t5_addr", 128'(mem_addr), 128'(0));
        check("t5_rdata", 128'(core_rdata), 128'(0));
        tick(0); tick(0);
        reset = 1'b0;
        tick(0);
        ack_q.delete();
        set_core(3, 0, 9, '0);
        set_core(0, 0, 8, '0);
        for (int n = 0; n < 5; n++) tick(0);
        check_order("t5_after", 0, 3);

        // 6: ten idle cycles.
        for (int n = 0; n < 10; n++) begin
            tick(0);
            check("t6_idle_en", 128'(mem_en), 128'(0));
            check("t6_idle_ack", 128'(core_ack), 128'(0));
        end

        // Random traffic over a small address window.
        for (int n = 0; n < 400; n++) tick(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
